// File: rtl/im_pair_collector.sv
// Sums IM/tao partial sums over a configurable number of beats per SNP pair,
// thresholds the IM total and queues passing pairs in a first-word fall-through FIFO.
module im_pair_collector #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 48,
  parameter int unsigned BEAT_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] IM_in,
  input  logic [DATA_WIDTH-1:0] tao_in,
  input  logic                  valid_in,
  input  logic [BEAT_WIDTH-1:0] cfg_beats,
  input  logic [ACC_WIDTH-1:0]  cfg_threshold,
  output logic                  stall,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ID_WIDTH-1:0]   out_id,
  output logic [ACC_WIDTH-1:0]  out_IM,
  output logic [ACC_WIDTH-1:0]  out_tao,
  output logic [31:0]           pairs_done,
  output logic                  overflow
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BC_W  = BEAT_WIDTH + 1;

  typedef enum logic {IDLE, ACCUM} state_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]  id;
    logic [ACC_WIDTH-1:0] im;
    logic [ACC_WIDTH-1:0] tao;
  } entry_t;

  state_t                state, state_next;
  logic [BEAT_WIDTH-1:0] beat_cnt, beat_cnt_next;
  logic [BEAT_WIDTH-1:0] beats_lat, beats_lat_next;
  logic [BEAT_WIDTH-1:0] beats_cfg, beats_eff;
  logic [ACC_WIDTH-1:0]  acc_im, acc_im_next;
  logic [ACC_WIDTH-1:0]  acc_tao, acc_tao_next;
  logic [ACC_WIDTH-1:0]  sum_im, sum_tao;
  logic                  last_beat, pass;

  logic [ID_WIDTH-1:0]   pair_id;
  logic                  res_pend;
  entry_t                res_q;

  entry_t                mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      occ;
  logic                  full, empty, push, pop, drop;

  // Beat sequencing: first beat loads, later beats add, last beat closes the pair
  always_comb begin
    state_next     = state;
    beat_cnt_next  = beat_cnt;
    beats_lat_next = beats_lat;
    acc_im_next    = acc_im;
    acc_tao_next   = acc_tao;

    beats_cfg = (cfg_beats == '0) ? BEAT_WIDTH'(1) : cfg_beats;
    beats_eff = (state == IDLE) ? beats_cfg : beats_lat;
    sum_im    = ((state == IDLE) ? '0 : acc_im)  + ACC_WIDTH'($signed(IM_in));
    sum_tao   = ((state == IDLE) ? '0 : acc_tao) + ACC_WIDTH'($signed(tao_in));
    last_beat = valid_in && ((BC_W'(beat_cnt) + BC_W'(1)) == BC_W'(beats_eff));
    pass      = $signed(sum_im) >= $signed(cfg_threshold);

    if (valid_in) begin
      acc_im_next  = sum_im;
      acc_tao_next = sum_tao;
      if (state == IDLE) beats_lat_next = beats_cfg;
      if (last_beat) begin
        state_next    = IDLE;
        beat_cnt_next = '0;
      end else begin
        state_next    = ACCUM;
        beat_cnt_next = beat_cnt + BEAT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      beats_lat <= '0;
      acc_im    <= '0;
      acc_tao   <= '0;
    end else begin
      state     <= state_next;
      beat_cnt  <= beat_cnt_next;
      beats_lat <= beats_lat_next;
      acc_im    <= acc_im_next;
      acc_tao   <= acc_tao_next;
    end
  end

  // Result stage: one-cycle hold of the closed pair before the FIFO write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_pend   <= 1'b0;
      res_q      <= '0;
      pair_id    <= '0;
      pairs_done <= '0;
    end else begin
      res_pend <= last_beat && pass;
      if (last_beat) begin
        res_q      <= '{id: pair_id, im: sum_im, tao: sum_tao};
        pair_id    <= pair_id + ID_WIDTH'(1);
        pairs_done <= pairs_done + 32'd1;
      end
    end
  end

  assign full  = (occ == CNT_W'(FIFO_DEPTH));
  assign empty = (occ == '0);
  assign pop   = !empty && out_ready;
  assign push  = res_pend && (!full || pop);
  assign drop  = res_pend && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= res_q;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      occ <= occ + CNT_W'(1);
      else if (pop && !push) occ <= occ - CNT_W'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  // Head fields are forced to zero while empty so reset and idle read clean
  assign out_valid = !empty;
  assign out_id    = empty ? '0 : mem[rd_ptr].id;
  assign out_IM    = empty ? '0 : mem[rd_ptr].im;
  assign out_tao   = empty ? '0 : mem[rd_ptr].tao;
  assign stall     = (BC_W'(occ) + BC_W'(res_pend)) >= BC_W'(FIFO_DEPTH - 1);

endmodule

// File: tb/tb_im_pair_collector.sv
// Randomized and directed bench for im_pair_collector with a queue-based reference model.
module tb_im_pair_collector;

  localparam int DW = 32;
  localparam int AW = 48;
  localparam int BW = 8;
  localparam int IW = 16;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] IM_in = '0;
  logic [DW-1:0] tao_in = '0;
  logic          valid_in = 1'b0;
  logic [BW-1:0] cfg_beats = '0;
  logic [AW-1:0] cfg_threshold = '0;
  logic          stall;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] out_id;
  logic [AW-1:0] out_IM;
  logic [AW-1:0] out_tao;
  logic [31:0]   pairs_done;
  logic          overflow;

  always #5 clk = ~clk;

  im_pair_collector #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW), .BEAT_WIDTH(BW), .ID_WIDTH(IW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst_n), .IM_in(IM_in), .tao_in(tao_in), .valid_in(valid_in),
    .cfg_beats(cfg_beats), .cfg_threshold(cfg_threshold), .stall(stall),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_IM(out_IM),
    .out_tao(out_tao), .pairs_done(pairs_done), .overflow(overflow)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference model: pair sums by plain arithmetic, result queue of bounded capacity
  typedef struct {
    int            id;
    logic [AW-1:0] im;
    logic [AW-1:0] tao;
  } item_t;

  item_t         exp_q[$];
  logic [AW-1:0] m_im = '0, m_tao = '0;
  int            m_n = 0, m_target = 1, m_id = 0;
  logic [31:0]   m_done = '0;
  logic          m_ovf = 1'b0;
  logic          m_pend = 1'b0;
  item_t         m_pend_item;
  int            got_ids[$];

  always @(posedge clk or negedge rst_n) begin : model
    item_t tmp;
    if (!rst_n) begin
      exp_q.delete();
      m_im = '0; m_tao = '0; m_n = 0; m_id = 0;
      m_done = '0; m_ovf = 1'b0; m_pend = 1'b0;
    end else begin
      if (out_ready && exp_q.size() > 0) tmp = exp_q.pop_front();
      if (m_pend) begin
        if (exp_q.size() < FD) exp_q.push_back(m_pend_item);
        else m_ovf = 1'b1;
      end
      m_pend = 1'b0;
      if (valid_in) begin
        if (m_n == 0) begin
          m_target = (cfg_beats == 0) ? 1 : int'(cfg_beats);
          m_im = '0;
          m_tao = '0;
        end
        m_im  = m_im  + AW'($signed(IM_in));
        m_tao = m_tao + AW'($signed(tao_in));
        m_n++;
        if (m_n == m_target) begin
          m_pend = ($signed(m_im) >= $signed(cfg_threshold));
          m_pend_item = '{id: m_id, im: m_im, tao: m_tao};
          m_id = (m_id + 1) % (1 << IW);
          m_done = m_done + 32'd1;
          m_n = 0;
        end
      end
    end
  end

  // Monitor: compare the presented head and status against the model every cycle
  always @(negedge clk) begin : monitor
    int occ_exp;
    occ_exp = exp_q.size() + (m_pend ? 1 : 0);
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    if (out_valid && exp_q.size() != 0) begin
      chk("head_id", 64'(out_id), 64'(IW'(exp_q[0].id)));
      chk("head_im", 64'(out_IM), 64'(exp_q[0].im));
      chk("head_tao", 64'(out_tao), 64'(exp_q[0].tao));
    end
    chk("stall", 64'(stall), 64'(occ_exp >= FD - 1));
    chk("pairs_done", 64'(pairs_done), 64'(m_done));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    if (out_valid && out_ready) got_ids.push_back(int'(out_id));
  end

  task automatic beat(input int im, input int tao, input int cfg);
    valid_in  = 1'b1;
    IM_in     = DW'(im);
    tao_in    = DW'(tao);
    cfg_beats = BW'(cfg);
    @(posedge clk); #1;
    valid_in  = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic apply_reset();
    valid_in = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic chk_ids(input string name, input int n);
    chk({name, "_count"}, 64'(got_ids.size()), 64'(n));
    for (int i = 0; i < n && i < got_ids.size(); i++)
      chk({name, "_id"}, 64'(got_ids[i]), 64'(i));
  endtask

  initial begin
    apply_reset();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_out_IM", 64'(out_IM), 64'd0);

    // Single beat, two-cycle latency
    cfg_threshold = '0;
    beat(5, 7, 1);
    chk("t1_not_yet", 64'(out_valid), 64'd0);
    idle(1);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_id", 64'(out_id), 64'd0);
    chk("t1_im", 64'(out_IM), 64'd5);
    chk("t1_tao", 64'(out_tao), 64'd7);
    chk("t1_done", 64'(pairs_done), 64'd1);
    out_ready = 1'b1; idle(1); out_ready = 1'b0;

    // Sign extension, wrap, cfg_beats ignored mid-pair
    apply_reset();
    beat(-1, 1, 3);
    beat(-2, 2, 1);
    beat(32'h7FFF_FFFF, 3, 0);
    idle(1);
    chk("t2_im", 64'(out_IM), 64'h0000_7FFF_FFFC);
    chk("t2_tao", 64'(out_tao), 64'd6);
    chk("t2_done", 64'(pairs_done), 64'd1);
    out_ready = 1'b1; idle(1); out_ready = 1'b0;

    // Threshold filtering: 9 fails, 10 passes
    apply_reset();
    cfg_threshold = AW'(10);
    beat(9, 0, 1);
    beat(10, 0, 1);
    idle(1);
    chk("t3_id", 64'(out_id), 64'd1);
    chk("t3_done", 64'(pairs_done), 64'd2);
    out_ready = 1'b1; idle(1); out_ready = 1'b0;
    chk("t3_single", 64'(out_valid), 64'd0);

    // Back-to-back two-beat pairs
    apply_reset();
    cfg_threshold = '0;
    got_ids.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) beat(i + 1, 2 * i, 2);
    idle(3);
    chk("t4_done", 64'(pairs_done), 64'd4);
    chk_ids("t4", 4);
    out_ready = 1'b0;

    // Backpressure with overflow, then drain in order
    apply_reset();
    for (int i = 0; i < 6; i++) beat(1, 1, 1);
    idle(2);
    chk("t5_ovf", 64'(overflow), 64'd1);
    chk("t5_stall", 64'(stall), 64'd1);
    got_ids.delete();
    out_ready = 1'b1; idle(6); out_ready = 1'b0;
    chk_ids("t5", 4);
    chk("t5_empty", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-pair with a non-empty FIFO
    apply_reset();
    beat(3, 4, 1);
    beat(100, 200, 3);
    beat(100, 200, 3);
    idle(1);
    chk("t6_pre_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_stall", 64'(stall), 64'd0);
    chk("t6_id", 64'(out_id), 64'd0);
    chk("t6_im", 64'(out_IM), 64'd0);
    chk("t6_tao", 64'(out_tao), 64'd0);
    chk("t6_done", 64'(pairs_done), 64'd0);
    chk("t6_ovf", 64'(overflow), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    beat(1, 2, 3);
    beat(4, 5, 3);
    beat(6, 7, 3);
    idle(1);
    chk("t6_new_id", 64'(out_id), 64'd0);
    chk("t6_new_im", 64'(out_IM), 64'd11);
    chk("t6_new_tao", 64'(out_tao), 64'd14);

    // Randomized traffic with random backpressure and thresholds
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      valid_in      = ($urandom % 4) != 0;
      IM_in         = (($urandom % 8) == 0) ? DW'($urandom) : DW'($urandom_range(0, 40) - 20);
      tao_in        = (($urandom % 8) == 0) ? DW'($urandom) : DW'($urandom_range(0, 40) - 20);
      cfg_beats     = BW'($urandom_range(0, 3));
      cfg_threshold = AW'($urandom_range(0, 40) - 10);
      out_ready     = ($urandom % 3) != 0;
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    out_ready = 1'b1;
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
